fpu_issue_controller: RTL and testbench
=======================================

Name: fpu_issue_controller

Overview:
Sequencer between the core's execute stage and the Fixed_Point_Unit; this block sits directly upstream of the FPU.
- Accepts one request at a time over a valid/ready handshake.
- Holds the operands and operation stable on the FPU inputs.
- Clears the FPU's sticky ready/state before each multi-cycle operation, waits for `ready` with a timeout, and returns the result plus destination tag over a valid/ready response handshake toward writeback.

Parameters:
- WIDTH, 32, operand/result width; must match the FPU.
- TAG_W, 5, destination-register tag width.
- MIN_WAIT, 2, cycles after the clear pulse before fpu_ready is trusted (MUL/SQRT only); must be >= 1.
- TIMEOUT, 64, maximum WAIT cycles before aborting (MUL/SQRT only); must be > MIN_WAIT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  operation, encoded as FPU_ADD/SUB/MUL/SQRT.
- req_operand_1  in  WIDTH  first operand; SQRT radicand.
- req_operand_2  in  WIDTH  second operand; ignored for SQRT.
- req_tag  in  TAG_W  destination tag.
- fpu_operand_1  out  WIDTH  registered operand to the FPU.
- fpu_operand_2  out  WIDTH  registered operand to the FPU.
- fpu_operation  out  2  registered operation to the FPU.
- fpu_clear  out  1  drives the FPU synchronous reset input.
- fpu_result  in  WIDTH  FPU result.
- fpu_ready  in  1  FPU ready.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  writeback accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_timeout  out  1  the operation aborted by timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state, mid-operation included) forces:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_timeout=0;
  - fpu_operand_1/2=0, fpu_operation=FPU_ADD, fpu_clear=1, wait counter=0.
  - Any in-flight operation is dropped and no response is produced.
- fpu_clear defaults to 0 and is 1 only in CLEAR. It therefore falls to 0 at the first clock edge after reset deassert.
- In IDLE, fpu_operation=FPU_ADD. This is harmless because the FPU's MUL/SQRT machines are not triggered by ADD.
- Request acceptance: a request is accepted at an edge where req_valid && req_ready. req_ready=1 only in IDLE.
  - At that edge, operands, op and tag are latched into the fpu_* and tag registers.
  - They are held constant until the controller returns to IDLE.
- States:
  - IDLE: accept request. ADD/SUB -> EXEC. MUL/SQRT -> CLEAR.
  - EXEC (1 cycle): capture fpu_result into rsp_result, rsp_timeout=0 -> RESP. fpu_ready is not checked; the FPU is combinational for ADD/SUB.
  - CLEAR (1 cycle): fpu_clear=1, counter=0 -> WAIT.
  - WAIT: counter increments every cycle. Transitions are checked in this priority order:
    1. counter >= MIN_WAIT-1 && fpu_ready: capture fpu_result, rsp_timeout=0 -> RESP.
    2. Otherwise, counter == TIMEOUT-1: rsp_result=0, rsp_timeout=1 -> RESP.
    3. Otherwise, stay in WAIT.
    - fpu_ready seen earlier than MIN_WAIT is ignored, because it is stale.
  - RESP: rsp_valid=1. rsp_result, rsp_tag and rsp_timeout are stable while rsp_ready=0. On rsp_ready -> IDLE with rsp_valid=0 at the next edge.
- Latency from accept edge to first rsp_valid cycle:
  - ADD/SUB: 2 cycles.
  - MUL/SQRT: 2 + max(MIN_WAIT, FPU latency) cycles.
- Throughput: one operation in flight. A new request is accepted no earlier than the cycle after the response handshake; there is no same-cycle response/request overlap.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.
- An unknown state decodes to IDLE.
- All outputs are registered except req_ready and busy, which decode the state.

Decomposition:
- Shared package/defines file:
  - FPU op encodings FPU_ADD=2'b00, FPU_SUB=2'b01, FPU_MUL=2'b10, FPU_SQRT=2'b11, shared with the FPU;
  - state encodings IDLE/EXEC/CLEAR/WAIT/RESP.
- One natural sub-module, fpu_wait_timer: counter with clear, enable, a min_reached output and an expired output.

Test Plan:
The bench uses a behavioural FPU model with configurable latency, FBITS=10.
- ADD: 0x600 + 0x800 (1.5 + 2.0) -> rsp_result=0xE00, rsp_timeout=0, rsp_valid exactly 2 cycles after accept, tag echoed.
- MUL, model latency 6: 0x600 * 0x800 -> rsp_result=0xC00, one fpu_clear pulse, stale ready held high before the clear is ignored.
- SQRT: 0x1000 -> rsp_result=0x800; operands and op stay stable on the fpu_* outputs throughout WAIT.
- Timeout: model never raises ready, TIMEOUT=64 -> rsp_timeout=1, rsp_result=0 after exactly 64 WAIT cycles, controller returns to IDLE.
- Backpressure: rsp_ready=0 for 5 cycles -> response held stable, req_ready=0, a second request is accepted only after the handshake.
- Async reset asserted mid-WAIT, between clock edges -> outputs take reset values immediately, no response is produced, the next request completes normally.

Source files
------------

// File: rtl/fpu_issue_controller_pkg.sv
// rtl/fpu_issue_controller_pkg.sv - FPU op and issue-controller state encodings
// Op codes are shared with the Fixed_Point_Unit and must not change.
package fpu_issue_controller_pkg;

  typedef enum logic [1:0] {
    FPU_ADD  = 2'b00,
    FPU_SUB  = 2'b01,
    FPU_MUL  = 2'b10,
    FPU_SQRT = 2'b11
  } fpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic is_multicycle(fpu_op_e op);
    return (op == FPU_MUL) || (op == FPU_SQRT);
  endfunction

endpackage

// File: rtl/fpu_issue_controller_timer.sv
// rtl/fpu_issue_controller_timer.sv - WAIT-state cycle counter for fpu_issue_controller
// min_reached_o gates trust in fpu_ready; expired_o marks the last permitted WAIT cycle.
module fpu_wait_timer #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic min_reached_o,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign min_reached_o = (count_q >= CW'(MIN_WAIT - 1));
  assign expired_o     = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_controller.sv
// rtl/fpu_issue_controller.sv - request/response sequencer in front of the Fixed_Point_Unit
// One operation in flight; MUL/SQRT get a clear pulse and a bounded wait for fpu_ready.
module fpu_issue_controller
  import fpu_issue_controller_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 5,
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_operand_1,
  input  logic [WIDTH-1:0] req_operand_2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  output logic             fpu_clear,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH-1:0] result_q, result_d;
  fpu_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             clear_q, clear_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             min_reached, expired;

  fpu_wait_timer #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_wait_timer (
    .clk_i         (clk),
    .rst_i         (reset),
    .clear_i       (state_q == ST_CLEAR),
    .enable_i      (state_q == ST_WAIT),
    .min_reached_o (min_reached),
    .expired_o     (expired)
  );

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    op_d      = op_q;
    tag_d     = tag_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op1_d   = req_operand_1;
          op2_d   = req_operand_2;
          op_d    = fpu_op_e'(req_op);
          tag_d   = req_tag;
          state_d = is_multicycle(fpu_op_e'(req_op)) ? ST_CLEAR : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d  = fpu_result;
        timeout_d = 1'b0;
        state_d   = ST_RESP;
      end
      ST_CLEAR: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // fpu_ready before min_reached may be left over from the previous op
        if (min_reached && fpu_ready) begin
          result_d  = fpu_result;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (expired) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_d    = FPU_ADD;
          state_d = ST_IDLE;
        end
      end
      default: begin
        op_d    = FPU_ADD;
        state_d = ST_IDLE;
      end
    endcase
    clear_d = (state_d == ST_CLEAR);
    valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      op_q      <= FPU_ADD;
      tag_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      clear_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      clear_q   <= clear_d;
      valid_q   <= valid_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign fpu_operand_1 = op1_q;
  assign fpu_operand_2 = op2_q;
  assign fpu_operation = op_q;
  assign fpu_clear     = clear_q;
  assign rsp_valid     = valid_q;
  assign rsp_result    = result_q;
  assign rsp_tag       = tag_q;
  assign rsp_timeout   = timeout_q;

endmodule

// File: tb/tb_fpu_issue_controller.sv
// tb/tb_fpu_issue_controller.sv - bench for fpu_issue_controller with a latency-configurable FPU model
// Expected results come from fixed-point arithmetic on the request, latencies from the cycle rules.
module tb_fpu_issue_controller;

  localparam int WIDTH    = 32;
  localparam int TAG_W    = 5;
  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_operand_1, req_operand_2;
  logic [TAG_W-1:0] req_tag;
  logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
  logic [1:0]       fpu_operation;
  logic             fpu_clear, fpu_ready;
  logic             rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_lat = 0;
  int          m_cnt = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_res = 32'hBAD0;
  bit          stale = 1'b0;

  fpu_issue_controller #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_operand_1(req_operand_1), .req_operand_2(req_operand_2), .req_tag(req_tag),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation), .fpu_clear(fpu_clear),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] isqrt(logic [63:0] v);
    logic [63:0] r = '0;
    logic [63:0] t;
    for (int i = 31; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= v) r = t;
    end
    return r[31:0];
  endfunction

  // FPU model: sticky ready after m_lat cycles counted from the clear edge; m_lat==0 never completes
  always @(posedge clk) begin
    if (fpu_clear) begin
      m_cnt   <= 1;
      m_ready <= 1'b0;
      m_res   <= 32'hBAD0;
    end else if (m_cnt != 0 && !m_ready && fpu_operation[1]) begin
      if (m_lat != 0 && m_cnt >= m_lat - 1) begin
        m_ready <= 1'b1;
        m_res   <= fpu_operation[0] ? isqrt(64'({fpu_operand_1, 10'b0}))
                                    : 32'((64'(fpu_operand_1) * 64'(fpu_operand_2)) >> 10);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign fpu_result = stale ? 32'hDEAD :
                      (fpu_operation == 2'd0) ? fpu_operand_1 + fpu_operand_2 :
                      (fpu_operation == 2'd1) ? fpu_operand_1 - fpu_operand_2 : m_res;
  assign fpu_ready  = stale | m_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return 32'((64'(a) * 64'(b)) / 1024);
      default: return 32'($rtoi($floor($sqrt(real'(a) * 1024.0))));
    endcase
  endfunction

  // Starts and ends at a negedge; the accept cycle is cycle 0.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input bit stl, input int bp,
                        output logic [31:0] got);
    logic [31:0] exp_res;
    bit          exp_to, steady, held;
    int          exp_lat, n, clears;
    exp_to  = op[1] && (lat == 0);
    exp_res = exp_to ? 32'd0 : ref_result(op, a, b);
    exp_lat = !op[1] ? 2 : exp_to ? 2 + TIMEOUT : 2 + ((lat > MIN_WAIT) ? lat : MIN_WAIT);
    @(negedge clk);
    m_lat = lat;
    stale = stl;
    req_op = op; req_operand_1 = a; req_operand_2 = b; req_tag = tag;
    req_valid = 1'b1; rsp_ready = 1'b0;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; clears = 0; steady = 1'b1;
    while (!rsp_valid && n < 200) begin
      clears += int'(fpu_clear);
      if (fpu_operand_1 !== a || (!op[0] && fpu_operand_2 !== b) || fpu_operation !== op ||
          !busy || req_ready) steady = 1'b0;
      if (n == 3) stale = 1'b0;
      @(negedge clk);
      n++;
    end
    stale = 1'b0;
    if (!rsp_valid) begin
      check("rsp_valid_bound", 64'(rsp_valid), 64'd1);
      got = '0;
      return;
    end
    got = rsp_result;
    check("latency", 64'(n), 64'(exp_lat));
    check("rsp_result", 64'(rsp_result), 64'(exp_res));
    check("rsp_tag", 64'(rsp_tag), 64'(tag));
    check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    check("clear_pulses", 64'(clears), 64'(op[1]));
    check("fpu_inputs_steady", 64'(steady), 64'd1);
    held = 1'b1;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_tag = ~tag;
      @(negedge clk);
      if (!rsp_valid || rsp_result !== got || rsp_tag !== tag || rsp_timeout !== exp_to ||
          req_ready) held = 1'b0;
    end
    if (bp > 0) check("rsp_held", 64'(held), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check("idle_after_hs", 64'(busy), 64'd0);
    check("idle_op_add", 64'(fpu_operation), 64'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a, b;
    logic [1:0]  op;
    int          lat;
    bit          seen;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = '0;
    req_operand_1 = '0; req_operand_2 = '0; req_tag = '0;
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_fpu_clear", 64'(fpu_clear), 64'd1);
    check("rst_fpu_op", 64'(fpu_operation), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("fpu_clear_falls", 64'(fpu_clear), 64'd0);

    run_op(2'd0, 32'h600, 32'h800, 5'd3, 0, 1'b0, 0, got);
    check("add_value", 64'(got), 64'hE00);
    run_op(2'd2, 32'h600, 32'h800, 5'd9, 6, 1'b1, 0, got);
    check("mul_value", 64'(got), 64'hC00);
    run_op(2'd3, 32'h1000, 32'h1234, 5'd17, 4, 1'b0, 0, got);
    check("sqrt_value", 64'(got), 64'h800);
    run_op(2'd2, 32'h600, 32'h800, 5'd1, 0, 1'b0, 1, got);
    check("timeout_value", 64'(got), 64'h0);
    run_op(2'd1, 32'h1800, 32'h400, 5'h1F, 0, 1'b0, 5, got);
    check("bp_sub_value", 64'(got), 64'h1400);

    @(negedge clk);
    m_lat = 0;
    req_op = 2'd3; req_operand_1 = 32'h900; req_operand_2 = '0; req_tag = 5'h15;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fpu_clear", 64'(fpu_clear), 64'd1);
    check("mid_rst_operand", 64'(fpu_operand_1), 64'd0);
    check("mid_rst_op", 64'(fpu_operation), 64'd0);
    check("mid_rst_tag", 64'(rsp_tag), 64'd0);
    check("mid_rst_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (TIMEOUT + 8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_rst", 64'(seen), 64'd0);
    run_op(2'd2, 32'h400, 32'hA00, 5'd6, 3, 1'b0, 0, got);
    check("post_rst_mul_value", 64'(got), 64'hA00);

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      if (op == 2'd2) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
      if (op == 2'd3) a = a & 32'hFFFFF;
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      run_op(op, a, b, 5'($urandom), lat, op[1] && ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, 3)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
